// File: rtl/pinmux_filt.sv
// ---------------------------------------------------------------------------
// pinmux_filt
// Any-to-any GPIO pin mux between the pad bank and the peripheral set,
// configured over a Wishbone slave port. Each GPIO input passes through a
// synchroniser and an optional glitch filter. Each input and output route has
// an optional polarity inversion. Each GPIO output can also be forced to 0, to 1
// or to hi-Z. A sticky LOCK bit freezes the whole configuration until reset.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wb_adr_i .. wb_ack_o      Wishbone slave; adr[13:12] region, adr[9:2] index
//   gpio_in                   raw pad inputs (asynchronous)
//   gpio_out, gpio_oeb        pad output value and active-low enable
//   peripheral_in             routed, filtered inputs to the peripherals
//   peripheral_out/_oeb       peripheral output values and active-low enables
//
// Register map
//   0 CTRL        [0] LOCK (write-1-to-set), [23:16] NUM_GPIOS
//   1 IN_SEL[i]   [7:0] SEL (0 = none, n = gpio n-1), [8] INV
//   2 OUT_SEL[g]  [7:0] SEL (0 = none, n = peripheral n-1), [8] INV, [10:9] MODE
//   3 FILT[g]     [FILT_BITS-1:0] threshold, 0 = bypass
// ---------------------------------------------------------------------------
module pinmux_filt #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_OUTPUTS = 8,
    parameter int NUM_GPIOS   = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [31:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    input  logic [NUM_GPIOS-1:0]   gpio_in,
    output logic [NUM_GPIOS-1:0]   gpio_out,
    output logic [NUM_GPIOS-1:0]   gpio_oeb,
    output logic [NUM_INPUTS-1:0]  peripheral_in,
    input  logic [NUM_OUTPUTS-1:0] peripheral_out,
    input  logic [NUM_OUTPUTS-1:0] peripheral_oeb
);

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_OUT  = 2'd2;
    localparam logic [1:0] REG_FILT = 2'd3;

    localparam logic [1:0] MODE_MUX  = 2'b00;
    localparam logic [1:0] MODE_LOW  = 2'b01;
    localparam logic [1:0] MODE_HIGH = 2'b10;

    localparam logic [FILT_BITS-1:0] FILT_ZERO = '0;
    localparam logic [FILT_BITS-1:0] FILT_ONE  = FILT_BITS'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic                   lock_q, lock_d;
    logic [8:0]             in_sel_q  [NUM_INPUTS];
    logic [8:0]             in_sel_d  [NUM_INPUTS];
    logic [10:0]            out_sel_q [NUM_GPIOS];
    logic [10:0]            out_sel_d [NUM_GPIOS];
    logic [FILT_BITS-1:0]   filt_q    [NUM_GPIOS];
    logic [FILT_BITS-1:0]   filt_d    [NUM_GPIOS];
    logic [FILT_BITS-1:0]   cnt_q     [NUM_GPIOS];
    logic [FILT_BITS-1:0]   cnt_d     [NUM_GPIOS];
    logic [SYNC_STAGES-1:0][NUM_GPIOS-1:0] sync_q;
    logic [NUM_GPIOS-1:0]   filt_val_q, filt_val_d;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic        bus_req;
    logic        wr_en;
    logic [1:0]  region;
    logic [7:0]  idx;
    logic [15:0] wmask;
    logic [31:0] rdata;

    assign bus_req = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en   = bus_req & wb_we_i & ~lock_q;
    assign region  = wb_adr_i[13:12];
    assign idx     = wb_adr_i[9:2];
    assign wmask   = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_adr_i[31:14], wb_adr_i[11:10], wb_adr_i[1:0],
                               wb_dat_i[31:16], wb_sel_i[3:2]};

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [15:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Register writes. Out-of-range indices match no entry and are dropped.
    logic [15:0] wr_tmp;
    always_comb begin
        lock_d    = lock_q;
        in_sel_d  = in_sel_q;
        out_sel_d = out_sel_q;
        filt_d    = filt_q;
        wr_tmp    = '0;
        if (wr_en) begin
            case (region)
                REG_CTRL: begin
                    if (wb_sel_i[0] && wb_dat_i[0]) lock_d = 1'b1;
                end
                REG_IN: begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (idx == 8'(i)) begin
                            wr_tmp      = merge16(16'(in_sel_q[i]), wb_dat_i[15:0], wmask);
                            in_sel_d[i] = wr_tmp[8:0];
                        end
                    end
                end
                REG_OUT: begin
                    for (int g = 0; g < NUM_GPIOS; g++) begin
                        if (idx == 8'(g)) begin
                            wr_tmp       = merge16(16'(out_sel_q[g]), wb_dat_i[15:0], wmask);
                            out_sel_d[g] = wr_tmp[10:0];
                        end
                    end
                end
                default: begin
                    for (int g = 0; g < NUM_GPIOS; g++) begin
                        if (idx == 8'(g)) begin
                            wr_tmp    = merge16(16'(filt_q[g]), wb_dat_i[15:0], wmask);
                            filt_d[g] = wr_tmp[FILT_BITS-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // Read mux; unmatched indices fall through to zero.
    always_comb begin
        rdata = 32'h0;
        case (region)
            REG_CTRL: rdata = {8'h00, 8'(NUM_GPIOS), 15'h0000, lock_q};
            REG_IN: begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (idx == 8'(i)) rdata = {23'h0, in_sel_q[i]};
                end
            end
            REG_OUT: begin
                for (int g = 0; g < NUM_GPIOS; g++) begin
                    if (idx == 8'(g)) rdata = {21'h0, out_sel_q[g]};
                end
            end
            default: begin
                for (int g = 0; g < NUM_GPIOS; g++) begin
                    if (idx == 8'(g)) rdata = 32'(filt_q[g]);
                end
            end
        endcase
    end

    assign ack_d = bus_req;
    assign dat_d = bus_req ? rdata : 32'h0;

    // -----------------------------------------------------------------------
    // Input path: synchroniser then glitch filter
    // -----------------------------------------------------------------------
    logic [NUM_GPIOS-1:0] gpio_s;
    logic [NUM_GPIOS-1:0] gpio_f;

    assign gpio_s = sync_q[SYNC_STAGES-1];

    // With the filter bypassed the stored value tracks s, so enabling the
    // filter later starts from the current pin level rather than a stale one.
    // The >= compare lets a threshold lowered mid-count fire on the next
    // mismatch instead of wrapping the counter.
    always_comb begin
        filt_val_d = filt_val_q;
        cnt_d      = cnt_q;
        gpio_f     = '0;
        for (int g = 0; g < NUM_GPIOS; g++) begin
            if (filt_q[g] == FILT_ZERO) begin
                gpio_f[g]     = gpio_s[g];
                filt_val_d[g] = gpio_s[g];
                cnt_d[g]      = FILT_ZERO;
            end else begin
                gpio_f[g] = filt_val_q[g];
                if (gpio_s[g] == filt_val_q[g]) begin
                    cnt_d[g] = FILT_ZERO;
                end else if (cnt_q[g] >= filt_q[g] - FILT_ONE) begin
                    filt_val_d[g] = gpio_s[g];
                    cnt_d[g]      = FILT_ZERO;
                end else begin
                    cnt_d[g] = cnt_q[g] + FILT_ONE;
                end
            end
        end
    end

    // Peripheral inputs: SEL = 0 or beyond NUM_GPIOS selects constant 0,
    // so INV alone ties the input high.
    logic [NUM_INPUTS-1:0] periph_in_c;
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            periph_in_c[i] = in_sel_q[i][8];
            for (int g = 0; g < NUM_GPIOS; g++) begin
                if (in_sel_q[i][7:0] == 8'(g + 1)) periph_in_c[i] = gpio_f[g] ^ in_sel_q[i][8];
            end
        end
    end
    assign peripheral_in = periph_in_c;

    // -----------------------------------------------------------------------
    // Output path
    // -----------------------------------------------------------------------
    logic [NUM_GPIOS-1:0] gpio_out_c;
    logic [NUM_GPIOS-1:0] gpio_oeb_c;
    always_comb begin
        for (int g = 0; g < NUM_GPIOS; g++) begin
            gpio_out_c[g] = 1'b0;
            gpio_oeb_c[g] = 1'b1;
            case (out_sel_q[g][10:9])
                MODE_MUX: begin
                    gpio_out_c[g] = out_sel_q[g][8];
                    for (int p = 0; p < NUM_OUTPUTS; p++) begin
                        if (out_sel_q[g][7:0] == 8'(p + 1)) begin
                            gpio_out_c[g] = peripheral_out[p] ^ out_sel_q[g][8];
                            gpio_oeb_c[g] = peripheral_oeb[p];
                        end
                    end
                end
                MODE_LOW: begin
                    gpio_out_c[g] = 1'b0;
                    gpio_oeb_c[g] = 1'b0;
                end
                MODE_HIGH: begin
                    gpio_out_c[g] = 1'b1;
                    gpio_oeb_c[g] = 1'b0;
                end
                default: begin
                    gpio_out_c[g] = 1'b0;
                    gpio_oeb_c[g] = 1'b1;
                end
            endcase
        end
    end
    assign gpio_out = gpio_out_c;
    assign gpio_oeb = gpio_oeb_c;

    // -----------------------------------------------------------------------
    // Sequential
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            lock_q     <= 1'b0;
            sync_q     <= '0;
            filt_val_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) in_sel_q[i] <= '0;
            for (int g = 0; g < NUM_GPIOS; g++) begin
                out_sel_q[g] <= '0;
                filt_q[g]    <= '0;
                cnt_q[g]     <= '0;
            end
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            lock_q     <= lock_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            filt_val_q <= filt_val_d;
            in_sel_q   <= in_sel_d;
            out_sel_q  <= out_sel_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_pinmux_filt.sv
module tb_pinmux_filt;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oeb;
    logic [7:0]  peripheral_in;
    logic [7:0]  peripheral_out;
    logic [7:0]  peripheral_oeb;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    pinmux_filt dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb_adr_i       (wb_adr),
        .wb_dat_i       (wb_dat),
        .wb_sel_i       (wb_sel),
        .wb_cyc_i       (wb_cyc),
        .wb_stb_i       (wb_stb),
        .wb_we_i        (wb_we),
        .wb_dat_o       (wb_dat_o),
        .wb_ack_o       (wb_ack_o),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out),
        .gpio_oeb       (gpio_oeb),
        .peripheral_in  (peripheral_in),
        .peripheral_out (peripheral_out),
        .peripheral_oeb (peripheral_oeb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we, output logic [31:0] rd);
        logic got;
        got    = 1'b0;
        rd     = 32'h0;
        wb_adr = adr;
        wb_dat = dat;
        wb_sel = sel;
        wb_we  = we;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (wb_ack_o) begin
                got = 1'b1;
                rd  = wb_dat_o;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        chk("ack", 32'(got), 32'h1);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        bus(adr, dat, sel, 1'b1, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        bus(adr, 32'h0, 4'hF, 1'b0, v);
        chk(tag, v, exp);
    endtask

    initial begin
        logic seen;
        rst            = 1'b1;
        wb_adr         = '0;
        wb_dat         = '0;
        wb_sel         = '0;
        wb_cyc         = 1'b0;
        wb_stb         = 1'b0;
        wb_we          = 1'b0;
        gpio_in        = '0;
        peripheral_out = '0;
        peripheral_oeb = 8'hFF;

        repeat (3) tick();
        chk("rst_oeb", gpio_oeb, 32'hFFFF_FFFF);
        chk("rst_out", gpio_out, 32'h0);
        chk("rst_pin", 32'(peripheral_in), 32'h0);
        chk("rst_ack", 32'(wb_ack_o), 32'h0);
        rst = 1'b0;
        tick();

        // CTRL read with strobe held: ack must last exactly one cycle
        wb_adr = 32'h0; wb_we = 1'b0; wb_sel = 4'hF;
        wb_cyc = 1'b1;  wb_stb = 1'b1;
        tick();
        chk("ctrl_ack1", 32'(wb_ack_o), 32'h1);
        chk("ctrl_dat", wb_dat_o, 32'h0020_0000);
        tick();
        chk("ctrl_ack2", 32'(wb_ack_o), 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();

        // IN_SEL[3] = gpio 4, no filter: 2-cycle latency
        wr(32'h100C, 32'h005, 4'b0011);
        gpio_in[4] = 1'b1;
        tick();
        chk("sync_1cyc", 32'(peripheral_in), 32'h00);
        tick();
        chk("sync_2cyc", 32'(peripheral_in), 32'h08);
        wr(32'h100C, 32'h105, 4'b0011);
        chk("in_inv_hi", 32'(peripheral_in), 32'h00);
        gpio_in[4] = 1'b0;
        repeat (2) tick();
        chk("in_inv_lo", 32'(peripheral_in), 32'h08);
        wr(32'h100C, 32'h005, 4'b0011);
        chk("in_noinv", 32'(peripheral_in), 32'h00);

        // FILT[4] = 3
        wr(32'h3010, 32'h3, 4'b0011);
        rd_chk("filt_rd", 32'h3010, 32'h3);
        gpio_in[4] = 1'b1;
        repeat (2) tick();
        gpio_in[4] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | peripheral_in[3];
        end
        chk("filt_pulse", 32'(seen), 32'h0);
        gpio_in[4] = 1'b1;
        repeat (4) tick();
        chk("filt_4cyc", 32'(peripheral_in), 32'h00);
        tick();
        chk("filt_5cyc", 32'(peripheral_in), 32'h08);

        // Output path on gpio 7
        peripheral_out = 8'h02;
        peripheral_oeb = 8'hFD;
        wr(32'h201C, 32'h002, 4'b0011);
        chk("mux_out", gpio_out, 32'h0000_0080);
        chk("mux_oeb", gpio_oeb, 32'hFFFF_FF7F);
        wr(32'h201C, 32'h602, 4'b0011);
        chk("hiz_out", gpio_out, 32'h0);
        chk("hiz_oeb", gpio_oeb, 32'hFFFF_FFFF);
        wr(32'h201C, 32'h102, 4'b0011);
        chk("inv_out", gpio_out, 32'h0);
        chk("inv_oeb", gpio_oeb, 32'hFFFF_FF7F);
        peripheral_out = 8'h00;
        #1;
        chk("inv_out0", gpio_out, 32'h0000_0080);
        peripheral_out = 8'h02;
        wr(32'h201C, 32'h202, 4'b0011);
        chk("low_out", gpio_out, 32'h0);
        chk("low_oeb", gpio_oeb, 32'hFFFF_FF7F);
        wr(32'h201C, 32'h402, 4'b0011);
        chk("high_out", gpio_out, 32'h0000_0080);
        chk("high_oeb", gpio_oeb, 32'hFFFF_FF7F);
        wr(32'h201C, 32'h109, 4'b0011);
        chk("badsel_out", gpio_out, 32'h0000_0080);
        chk("badsel_oeb", gpio_oeb, 32'hFFFF_FFFF);

        // Out-of-range index
        wr(32'h20A0, 32'h7FF, 4'b0011);
        rd_chk("oor_rd", 32'h20A0, 32'h0);
        chk("oor_out", gpio_out, 32'h0000_0080);
        chk("oor_oeb", gpio_oeb, 32'hFFFF_FFFF);
        rd_chk("out7_rd", 32'h201C, 32'h109);

        // Byte enables and ignored upper bytes
        wr(32'h1000, 32'h1FF, 4'b0010);
        rd_chk("be_rd", 32'h1000, 32'h100);
        chk("be_pin", 32'(peripheral_in), 32'h09);
        wr(32'h3010, 32'hFFFF_0005, 4'b1111);
        rd_chk("upper_rd", 32'h3010, 32'h5);

        // Lock
        wr(32'h0, 32'h1, 4'b0001);
        rd_chk("lock_rd", 32'h0, 32'h0020_0001);
        wr(32'h2000, 32'h400, 4'b0011);
        rd_chk("locked_rd", 32'h2000, 32'h0);
        chk("locked_out", gpio_out, 32'h0000_0080);

        // Reset during a transaction
        wb_adr = 32'h0; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        #2;
        rst = 1'b1;
        tick();
        chk("midrst_ack", 32'(wb_ack_o), 32'h0);
        chk("midrst_oeb", gpio_oeb, 32'hFFFF_FFFF);
        chk("midrst_pin", 32'(peripheral_in), 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rst = 1'b0;
        tick();
        rd_chk("unlock_rd", 32'h0, 32'h0020_0000);
        wr(32'h2000, 32'h400, 4'b0011);
        rd_chk("unlocked_rd", 32'h2000, 32'h400);
        chk("unlocked_out", gpio_out, 32'h0000_0001);
        chk("unlocked_oeb", gpio_oeb, 32'hFFFF_FFFE);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
